lamp_draw_ctrl: RTL and testbench
=================================

Name: lamp_draw_ctrl

Overview:
- Sequencer that renders the 26-lamp Enigma lampboard into the pixel-plot port of the VGA framebuffer.
- Walks each lamp's 7x7 cell and emits one pixel per handshake.
- The cell is a rounded lamp border with the letter glyph cut out.
- Does a full redraw on request and after reset; otherwise redraws only the two lamps affected by a change of the lit letter.

Parameters:
- X0, 8'd8, x pixel of lamp 0 top-left
- Y0, 7'd40, y pixel of lamp 0 top-left
- PITCH, 4'd8, cell-to-cell spacing in pixels, both axes; must be >= 7
- PER_ROW, 5'd9, lamps per screen row; lamps are in alphabetical order, row-major
- LIT_COL, 3'b110, lamp body colour when lit
- DARK_COL, 3'b001, lamp body colour when unlit
- BG_COL, 3'b000, background and glyph colour

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- lit  in  26  one-hot lit letter, bit0=A ... bit25=Z; zero or multi-hot means no lamp lit
- start  in  1  one-cycle full-redraw request
- pix_ready  in  1  framebuffer accepts the pixel this cycle
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel valid
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse when a redraw job completes

Behaviour:
- Async reset (resetn=0):
  - x=0, y=0, colour=0, plot=0, busy=0, done=0
  - drawn_idx=NONE (5'd31), full_pend=1, part_pend=0
  - The first edge after release therefore starts a full redraw.
- lit decode: one-hot to 5-bit idx 0..25; any other value gives NONE.
- States:
  - IDLE
  - SETUP: select lamp, fetch glyph, compute cell origin; 1 cycle
  - PLOT: 49 pixels
  - NEXT: choose next lamp or finish; 1 cycle
- IDLE exit, priority order:
  - full_pend or start: full job, lamps 0..25 in order; latch cur_idx=decoded lit; clear both pend flags.
  - Else decoded lit != drawn_idx: partial job of up to two lamps, old drawn_idx first (drawn dark), then new idx (drawn lit). A NONE entry is skipped; if both are NONE, nothing is plotted. Latch cur_idx.
- Cell mask, row-major, bit 48 = (row0,col0):
  - row0 and row6 = 0111110
  - rows 1..5 = 1, ~glyph_row, 1
  - glyph_row r is the 5-bit glyph slice, MSB first
  - mask 1 -> LIT_COL if lamp==cur_idx else DARK_COL; mask 0 -> BG_COL
- Coordinates:
  - x = X0 + (lamp % PER_ROW)*PITCH + col
  - y = Y0 + (lamp / PER_ROW)*PITCH + row
  - truncate to port width, no saturation
- Handshake:
  - In PLOT, plot=1 and x/y/colour stay stable until a cycle with pix_ready=1; the pixel counter advances on that edge.
  - The pixel after col6,row6 goes to NEXT.
  - pix_ready is ignored when plot=0.
- Timing and counts:
  - start at edge N gives SETUP at N+1 and first plot=1 during the cycle after N+1.
  - Full job = 1274 beats; with pix_ready tied 1 it takes 26*51 cycles plus 1.
- Completion: the NEXT state after the last lamp sets drawn_idx=cur_idx, pulses done, and returns to IDLE.
- Requests while busy:
  - start sets full_pend.
  - lit changes are not latched; they are re-evaluated in IDLE against drawn_idx, so intermediate values are dropped.
  - A full job always follows an in-flight partial job if full_pend is set.
- Reset mid-job aborts immediately; plot drops asynchronously.

Decomposition:
- Shared package lamp_pkg:
  - lamp index width (5)
  - NONE=5'd31
  - NUM_LAMPS=26
  - CELL=7
  - border row constant 7'b0111110
  - state encoding
- Sub-module lamp_glyph_rom: 5-bit index in, 25-bit glyph out. Same glyph set as the lampboard letter table; blank for index >= 26.
- The controller is FSM plus counters (lamp, row, col) plus one-hot decoder.

Test Plan:
- Reset release with lit=26'h1 and pix_ready=1 -> exactly 1274 plots, then done pulse.
  - First pixel: x=8, y=40, colour=BG.
  - Pixel (row1,col3) of lamp 0 is BG (A glyph centre).
  - Pixel (row1,col1) of lamp 0 is LIT_COL.
  - drawn_idx=0.
- Idle with drawn A; lit changes 26'h1 -> 26'h2 -> exactly 98 plots.
  - First 49 at lamp 0 origin (8,40), body DARK_COL.
  - Next 49 at (16,40), body LIT_COL.
  - Then done.
- lit=26'h3 (multi-hot) after drawn B -> 49 plots of lamp 1 in DARK_COL only; drawn_idx=NONE.
- pix_ready held 0 for 5 cycles mid-PLOT -> plot stays 1 and x/y/colour unchanged for all 5 cycles, then advance by one pixel.
- start pulsed during a partial job -> partial completes with done, then a full 1274-plot job starts without lit change.
  - Lamp 9 (J) origin is (8,48).
  - Lamp 25 (Z) origin is (64,56).
- resetn low during PLOT -> plot=0 and busy=0 immediately; after release a full redraw restarts at lamp 0.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared constants, state encoding and lit-letter decode for the lampboard renderer.
package lamp_pkg;

  localparam int unsigned IDX_W     = 5;
  localparam int unsigned NUM_LAMPS = 26;
  localparam int unsigned CELL      = 7;

  localparam logic [IDX_W-1:0] IDX_NONE  = 5'd31;
  localparam logic [IDX_W-1:0] LAST_LAMP = IDX_W'(NUM_LAMPS - 1);
  localparam logic [2:0]       CELL_LAST = 3'(CELL - 1);
  localparam logic [CELL-1:0]  BORDER_ROW = 7'b0111110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PLOT,
    ST_NEXT
  } state_t;

  // One-hot letter to lamp index; zero or multi-hot yields IDX_NONE.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_LAMPS-1:0] v);
    logic [IDX_W-1:0] idx;
    int unsigned      hits;
    idx  = '0;
    hits = 0;
    for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
      if (v[i]) begin
        idx  = IDX_W'(i);
        hits = hits + 1;
      end
    end
    return (hits == 1) ? idx : IDX_NONE;
  endfunction

endpackage

// File: rtl/lamp_draw_ctrl_glyph_rom.sv
// 5x5 letter glyphs A..Z, row 0 in bits [24:20], MSB = leftmost column.
module lamp_glyph_rom
  import lamp_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [24:0]      glyph_o
);

  always_comb begin
    glyph_o = '0;
    case (idx_i)
      5'd0:  glyph_o = 25'b01110_10001_11111_10001_10001;
      5'd1:  glyph_o = 25'b11110_10001_11110_10001_11110;
      5'd2:  glyph_o = 25'b01111_10000_10000_10000_01111;
      5'd3:  glyph_o = 25'b11110_10001_10001_10001_11110;
      5'd4:  glyph_o = 25'b11111_10000_11110_10000_11111;
      5'd5:  glyph_o = 25'b11111_10000_11110_10000_10000;
      5'd6:  glyph_o = 25'b01111_10000_10011_10001_01111;
      5'd7:  glyph_o = 25'b10001_10001_11111_10001_10001;
      5'd8:  glyph_o = 25'b11111_00100_00100_00100_11111;
      5'd9:  glyph_o = 25'b00111_00010_00010_10010_01100;
      5'd10: glyph_o = 25'b10010_10100_11000_10100_10010;
      5'd11: glyph_o = 25'b10000_10000_10000_10000_11111;
      5'd12: glyph_o = 25'b10001_11011_10101_10001_10001;
      5'd13: glyph_o = 25'b10001_11001_10101_10011_10001;
      5'd14: glyph_o = 25'b01110_10001_10001_10001_01110;
      5'd15: glyph_o = 25'b11110_10001_11110_10000_10000;
      5'd16: glyph_o = 25'b01110_10001_10101_10010_01101;
      5'd17: glyph_o = 25'b11110_10001_11110_10100_10010;
      5'd18: glyph_o = 25'b01111_10000_01110_00001_11110;
      5'd19: glyph_o = 25'b11111_00100_00100_00100_00100;
      5'd20: glyph_o = 25'b10001_10001_10001_10001_01110;
      5'd21: glyph_o = 25'b10001_10001_10001_01010_00100;
      5'd22: glyph_o = 25'b10001_10001_10101_11011_10001;
      5'd23: glyph_o = 25'b10001_01010_00100_01010_10001;
      5'd24: glyph_o = 25'b10001_01010_00100_00100_00100;
      5'd25: glyph_o = 25'b11111_00010_00100_01000_11111;
      default: glyph_o = '0;
    endcase
  end

endmodule

// File: rtl/lamp_draw_ctrl.sv
// Lampboard renderer: walks 7x7 lamp cells and streams pixels to the framebuffer plot port.
module lamp_draw_ctrl
  import lamp_pkg::*;
#(
  parameter logic [7:0] X0       = 8'd8,
  parameter logic [6:0] Y0       = 7'd40,
  parameter logic [3:0] PITCH    = 4'd8,
  parameter logic [4:0] PER_ROW  = 5'd9,
  parameter logic [2:0] LIT_COL  = 3'b110,
  parameter logic [2:0] DARK_COL = 3'b001,
  parameter logic [2:0] BG_COL   = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [25:0] lit,
  input  logic        start,
  input  logic        pix_ready,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lamp_q, lamp_d;
  logic [IDX_W-1:0] second_q, second_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] drawn_q, drawn_d;
  logic             full_job_q, full_job_d;
  logic             full_pend_q, full_pend_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [24:0]      glyph_q, glyph_d;
  logic [7:0]       ox_q, ox_d;
  logic [6:0]       oy_q, oy_d;

  logic [24:0]      rom_glyph;
  logic [IDX_W-1:0] lit_idx;
  logic [4:0]       cell_c, cell_r;
  logic [7:0]       off_x;
  logic [6:0]       off_y;
  logic [4:0]       gbit;
  logic             mask_bit;
  logic             last_lamp;

  lamp_glyph_rom u_rom (
    .idx_i   (lamp_q),
    .glyph_o (rom_glyph)
  );

  assign lit_idx = onehot_idx(lit);
  assign cell_c  = lamp_q % PER_ROW;
  assign cell_r  = lamp_q / PER_ROW;
  assign off_x   = {3'b000, cell_c} * {4'b0000, PITCH};
  assign off_y   = {2'b00, cell_r} * {3'b000, PITCH};

  // Rows 1..5 map to glyph rows 0..4, cols 1..5 to glyph cols 0..4.
  assign gbit = 5'd30 - ({2'b00, row_q} * 5'd5) - {2'b00, col_q};

  always_comb begin
    mask_bit = 1'b0;
    if (row_q == 3'd0 || row_q == CELL_LAST) mask_bit = BORDER_ROW[CELL_LAST - col_q];
    else if (col_q == 3'd0 || col_q == CELL_LAST) mask_bit = 1'b1;
    else mask_bit = ~glyph_q[gbit];
  end

  assign last_lamp = full_job_q ? (lamp_q == LAST_LAMP) : (second_q == IDX_NONE);

  assign plot   = (state_q == ST_PLOT);
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_NEXT) && last_lamp;
  assign x      = plot ? (ox_q + {5'b00000, col_q}) : '0;
  assign y      = plot ? (oy_q + {4'b0000, row_q}) : '0;
  assign colour = !plot    ? '0 :
                  mask_bit ? ((lamp_q == cur_q) ? LIT_COL : DARK_COL) : BG_COL;

  always_comb begin
    state_d     = state_q;
    lamp_d      = lamp_q;
    second_d    = second_q;
    cur_d       = cur_q;
    drawn_d     = drawn_q;
    full_job_d  = full_job_q;
    full_pend_d = full_pend_q;
    row_d       = row_q;
    col_d       = col_q;
    glyph_d     = glyph_q;
    ox_d        = ox_q;
    oy_d        = oy_q;

    if (start && state_q != ST_IDLE) full_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (full_pend_q || start) begin
          full_job_d  = 1'b1;
          full_pend_d = 1'b0;
          lamp_d      = '0;
          second_d    = IDX_NONE;
          cur_d       = lit_idx;
          state_d     = ST_SETUP;
        end else if (lit_idx != drawn_q) begin
          // Old lamp first (goes dark), then the new one; a NONE slot is skipped.
          full_job_d = 1'b0;
          cur_d      = lit_idx;
          if (drawn_q != IDX_NONE) begin
            lamp_d   = drawn_q;
            second_d = lit_idx;
          end else begin
            lamp_d   = lit_idx;
            second_d = IDX_NONE;
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        glyph_d = rom_glyph;
        ox_d    = X0 + off_x;
        oy_d    = Y0 + off_y;
        row_d   = '0;
        col_d   = '0;
        state_d = ST_PLOT;
      end
      ST_PLOT: begin
        if (pix_ready) begin
          if (col_q == CELL_LAST) begin
            col_d = '0;
            if (row_q == CELL_LAST) state_d = ST_NEXT;
            else row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      ST_NEXT: begin
        if (last_lamp) begin
          drawn_d = cur_q;
          state_d = ST_IDLE;
        end else if (full_job_q) begin
          lamp_d  = lamp_q + 5'd1;
          state_d = ST_SETUP;
        end else begin
          lamp_d   = second_q;
          second_d = IDX_NONE;
          state_d  = ST_SETUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      lamp_q      <= '0;
      second_q    <= IDX_NONE;
      cur_q       <= IDX_NONE;
      drawn_q     <= IDX_NONE;
      full_job_q  <= 1'b0;
      full_pend_q <= 1'b1;
      row_q       <= '0;
      col_q       <= '0;
      glyph_q     <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
    end else begin
      state_q     <= state_d;
      lamp_q      <= lamp_d;
      second_q    <= second_d;
      cur_q       <= cur_d;
      drawn_q     <= drawn_d;
      full_job_q  <= full_job_d;
      full_pend_q <= full_pend_d;
      row_q       <= row_d;
      col_q       <= col_d;
      glyph_q     <= glyph_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
    end
  end

endmodule

// File: tb/tb_lamp_draw_ctrl.sv
// Scoreboard bench for lamp_draw_ctrl: a reference model queues expected pixels/done events, a monitor checks them.
module tb_lamp_draw_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [25:0] lit;
  logic        start;
  logic        pix_ready = 1'b1;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  always #5 clk = ~clk;

  lamp_draw_ctrl #(
    .X0(8'd8), .Y0(7'd40), .PITCH(4'd8), .PER_ROW(5'd9),
    .LIT_COL(3'b110), .DARK_COL(3'b001), .BG_COL(3'b000)
  ) dut (
    .clk(clk), .resetn(resetn), .lit(lit), .start(start), .pix_ready(pix_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t        sb[$];
  logic [24:0] font[26];
  int tests = 0, fails = 0, done_cnt = 0, exp_done = 0;
  int rdy_mode = 0;
  int drawn_m = 31;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [25:0] v);
    int n = 0, k = 31;
    for (int i = 0; i < 26; i++) if (v[i]) begin n++; k = i; end
    return (n == 1) ? k : 31;
  endfunction

  function automatic logic [2:0] model_col(input int lamp, input int r, input int c, input int cur);
    bit body;
    if (r == 0 || r == 6)      body = (c >= 1 && c <= 5);
    else if (c == 0 || c == 6) body = 1'b1;
    else                       body = !font[lamp][24 - 5*(r-1) - (c-1)];
    return body ? ((lamp == cur) ? 3'b110 : 3'b001) : 3'b000;
  endfunction

  task automatic push_lamp(input int lamp, input int cur);
    exp_t e;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        e.is_done = 1'b0;
        e.x = 8'(8 + (lamp % 9) * 8 + c);
        e.y = 7'(40 + (lamp / 9) * 8 + r);
        e.c = model_col(lamp, r, c, cur);
        sb.push_back(e);
      end
  endtask

  task automatic push_done();
    exp_t e;
    e = '0;
    e.is_done = 1'b1;
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic push_full(input int cur);
    for (int l = 0; l < 26; l++) push_lamp(l, cur);
    push_done();
    drawn_m = cur;
  endtask

  task automatic set_lit(input logic [25:0] v);
    int d;
    d = dec(v);
    if (d != drawn_m) begin
      if (drawn_m != 31) push_lamp(drawn_m, d);
      if (d != 31) push_lamp(d, d);
      push_done();
      drawn_m = d;
    end
    lit = v;
  endtask

  task automatic do_start(input logic [25:0] v);
    push_full(dec(v));
    lit   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt < exp_done && n < budget) begin @(posedge clk); n++; end
    #1;
    chk(name, 32'(done_cnt >= exp_done), 32'd1);
  endtask

  task automatic wait_plot(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!plot && n < budget) begin @(negedge clk); n++; end
    chk(name, 32'(plot), 32'd1);
  endtask

  // Monitor: every accepted pixel and every done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (plot && pix_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, want nothing", x, y, colour);
        end else begin
          e = sb.pop_front();
          if (e.is_done || {x, y, colour} !== {e.x, e.y, e.c}) begin
            fails++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d, want done=%0d x=%0d y=%0d c=%0d",
                     x, y, colour, e.is_done, e.x, e.y, e.c);
          end
        end
      end
      if (done) begin
        done_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got done, want nothing");
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            fails++;
            $display("FAIL done_early: got done, want pixel x=%0d y=%0d c=%0d", e.x, e.y, e.c);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = 1'b0;
      endcase
    end
  end

  initial begin
    int n;
    logic [17:0] held;
    logic [25:0] v;
    font[0]  = 25'b01110_10001_11111_10001_10001;  font[1]  = 25'b11110_10001_11110_10001_11110;
    font[2]  = 25'b01111_10000_10000_10000_01111;  font[3]  = 25'b11110_10001_10001_10001_11110;
    font[4]  = 25'b11111_10000_11110_10000_11111;  font[5]  = 25'b11111_10000_11110_10000_10000;
    font[6]  = 25'b01111_10000_10011_10001_01111;  font[7]  = 25'b10001_10001_11111_10001_10001;
    font[8]  = 25'b11111_00100_00100_00100_11111;  font[9]  = 25'b00111_00010_00010_10010_01100;
    font[10] = 25'b10010_10100_11000_10100_10010;  font[11] = 25'b10000_10000_10000_10000_11111;
    font[12] = 25'b10001_11011_10101_10001_10001;  font[13] = 25'b10001_11001_10101_10011_10001;
    font[14] = 25'b01110_10001_10001_10001_01110;  font[15] = 25'b11110_10001_11110_10000_10000;
    font[16] = 25'b01110_10001_10101_10010_01101;  font[17] = 25'b11110_10001_11110_10100_10010;
    font[18] = 25'b01111_10000_01110_00001_11110;  font[19] = 25'b11111_00100_00100_00100_00100;
    font[20] = 25'b10001_10001_10001_10001_01110;  font[21] = 25'b10001_10001_10001_01010_00100;
    font[22] = 25'b10001_10001_10101_11011_10001;  font[23] = 25'b10001_01010_00100_01010_10001;
    font[24] = 25'b10001_01010_00100_00100_00100;  font[25] = 25'b11111_00010_00100_01000_11111;

    resetn = 1'b0; lit = 26'h1; start = 1'b0;
    #1;
    chk("reset_outputs", {x, y, colour, plot, busy, done}, '0);

    // Power-up full redraw with pix_ready tied high: 26*51+1 cycles including the idle cycle.
    push_full(0);
    @(negedge clk); resetn = 1'b1;
    n = 0;
    while (done_cnt < 1 && n < 3000) begin @(posedge clk); n++; end
    #1;
    chk("full_cycles", n, 1327);
    chk("full_queue_empty", sb.size(), 0);

    rdy_mode = 1;
    set_lit(26'h2);
    wait_done(2000, "partial_a_to_b");
    set_lit(26'h3);
    wait_done(2000, "multihot_clears");
    chk("multihot_queue_empty", sb.size(), 0);

    // Stall: plot and pixel held for 5 cycles with pix_ready low.
    set_lit(26'h1 << 5);
    wait_plot(100, "stall_reach_plot");
    repeat (10) @(negedge clk);
    rdy_mode = 2;
    @(posedge clk); #2;
    held = {x, y, colour};
    chk("stall_plot_start", 32'(plot), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_plot", 32'(plot), 32'd1);
      chk("stall_pixel", 32'({x, y, colour}), 32'(held));
    end
    rdy_mode = 1;
    wait_done(2000, "stall_done");

    // start during a partial job queues a full job behind it.
    set_lit(26'h1 << 12);
    wait_plot(100, "partial_busy");
    @(posedge clk); #1;
    start = 1'b1;
    push_full(drawn_m);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6000, "partial_then_full");

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 9))
        0:       v = '0;
        1:       v = (26'h1 << $urandom_range(0, 12)) | (26'h1 << $urandom_range(13, 25));
        default: v = 26'h1 << $urandom_range(0, 25);
      endcase
      if ($urandom_range(0, 5) == 0) do_start(v);
      else set_lit(v);
      wait_done(6000, "random_job");
    end

    // Asynchronous reset in the middle of a cell.
    set_lit(26'h1 << 25);
    wait_plot(100, "reset_reach_plot");
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_mid_plot", 32'(plot), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    sb.delete();
    exp_done = done_cnt;
    push_full(dec(lit));
    @(negedge clk); resetn = 1'b1;
    wait_done(6000, "redraw_after_reset");

    repeat (5) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    chk("final_done_count", done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
